// File: rtl/drm_17x256_fifo_ctrl.sv
// drm_17x256_fifo_ctrl: single-clock first-word-fall-through FIFO controller
// for a simple dual-port RAM with a 1-cycle registered read. A 2-entry output
// buffer hides the read latency so the downstream stream can pop every cycle.
module drm_17x256_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 17,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned AF_THRESH  = 240,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int unsigned         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  infl;
  logic [1:0]            ob_cnt;
  logic [DATA_WIDTH-1:0] ob0;
  logic [DATA_WIDTH-1:0] ob1;

  logic       push;
  logic       pop;
  logic       fetch;
  logic [2:0] occ;
  logic [1:0] arr_slot;

  // Handshakes, fetch decision and arrival slot from registered state.
  always_comb begin
    s_ready  = !rst && (ram_cnt != DEPTH_CNT);
    push     = s_valid && s_ready;
    pop      = m_valid && m_ready;
    // Buffer occupancy once this cycle's pop and the pending arrival settle;
    // fetch only if the fetched word is guaranteed a free slot.
    occ      = 3'(ob_cnt) + 3'(infl) - 3'(pop);
    fetch    = (ram_cnt != '0) && (occ < 3'd2);
    arr_slot = ob_cnt - 2'(pop);
  end

  assign m_valid      = (ob_cnt != 2'd0);
  assign m_data       = ob0;
  assign count        = ram_cnt + (ADDR_WIDTH+1)'(infl) + (ADDR_WIDTH+1)'(ob_cnt);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign ram_wr_data  = s_data;
  assign ram_wr_addr  = wr_ptr;
  assign ram_wr_en    = push;
  assign ram_rd_addr  = rd_ptr;

  // RAM pointers, unfetched-word count and in-flight flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      infl    <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (fetch) rd_ptr <= rd_ptr + 1'b1;
      case ({push, fetch})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
      infl <= fetch;
    end
  end

  // Output buffer: shift on pop, then land the arriving RAM word.
  always_ff @(posedge clk) begin
    if (rst) begin
      ob_cnt <= 2'd0;
      ob0    <= '0;
      ob1    <= '0;
    end else begin
      if (pop) ob0 <= ob1;
      // Arrival is written after the shift so a same-cycle pop into an
      // emptied head slot lands in ob0.
      if (infl) begin
        if (arr_slot == 2'd0) ob0 <= ram_rd_data;
        else                  ob1 <= ram_rd_data;
      end
      ob_cnt <= ob_cnt - 2'(pop) + 2'(infl);
    end
  end

endmodule

// File: tb/tb_drm_17x256_fifo_ctrl.sv
// Testbench for drm_17x256_fifo_ctrl: behavioural RAM, table-driven reset and
// single-word vectors, and a scoreboard monitor for order/count checks.
module tb_drm_17x256_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [16:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [16:0] m_data;
  logic [8:0]  count;
  logic        almost_full;
  logic        almost_empty;
  logic [16:0] ram_wr_data;
  logic [7:0]  ram_wr_addr;
  logic        ram_wr_en;
  logic [7:0]  ram_rd_addr;
  logic [16:0] ram_rd_data;

  int checks = 0;
  int errors = 0;

  logic [16:0] sb[$];
  int          mcount = 0;

  always #5 clk = ~clk;

  drm_17x256_fifo_ctrl #(
    .DATA_WIDTH(17),
    .ADDR_WIDTH(8),
    .AF_THRESH(240),
    .AE_THRESH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .count(count),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .ram_wr_data(ram_wr_data),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_en(ram_wr_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data)
  );

  // Simple dual-port RAM, registered read, no output register.
  logic [16:0] mem [256];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle.
  task automatic cyc(input logic r, input logic v, input logic [16:0] d, input logic mr);
    @(negedge clk);
    rst     = r;
    s_valid = v;
    s_data  = d;
    m_ready = mr;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 17'h0, 1'b0);
    cyc(1'b1, 1'b0, 17'h0, 1'b0);
  endtask

  // Scoreboard monitor: count/threshold model and in-order data check.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      chk("rst_s_ready", s_ready, 0);
      chk("rst_wr_en", ram_wr_en, 0);
      sb.delete();
      mcount = 0;
    end else begin
      chk("count", count, mcount);
      chk("almost_empty", almost_empty, (mcount <= 2));
      chk("almost_full", almost_full, (mcount >= 240));
      if (s_valid && s_ready) begin
        chk("ram_wr_data", ram_wr_data, s_data);
        sb.push_back(s_data);
        mcount++;
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("pop_nonempty_sb", 0, 1);
        end else begin
          chk("m_data_order", m_data, sb.pop_front());
        end
        mcount--;
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        sv;
    logic [16:0] sd;
    logic        mr;
    logic        full;
    logic        e_sr;
    logic        e_we;
    logic [7:0]  e_wa;
    logic [7:0]  e_ra;
    logic        e_mv;
    logic [16:0] e_md;
    logic [8:0]  e_cnt;
    logic        e_ae;
    logic        e_af;
  } vec_t;

  vec_t tv[8];

  initial begin
    static int acc = 0;
    static int pushed = 0;
    static int popped = 0;
    static int first_valid = -1;
    static int bubbles = 0;
    static int wraps = 0;
    static bit done = 0;

    // T1 reset with s_valid high, then T2 single word 0x1ABCD.
    //             rst   sv    sd         mr    full  sr    we    wa     ra     mv    md          cnt   ae    af
    tv[0] = '{1'b1, 1'b1, 17'h0,     1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 17'h0,     9'd0, 1'b1, 1'b0};
    tv[1] = '{1'b1, 1'b1, 17'h0,     1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 17'h0,     9'd0, 1'b1, 1'b0};
    tv[2] = '{1'b0, 1'b0, 17'h0,     1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 17'h0,     9'd0, 1'b1, 1'b0};
    tv[3] = '{1'b0, 1'b1, 17'h1ABCD, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 17'h0,     9'd0, 1'b1, 1'b0};
    tv[4] = '{1'b0, 1'b0, 17'h0,     1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0, 17'h0,     9'd1, 1'b1, 1'b0};
    tv[5] = '{1'b0, 1'b0, 17'h0,     1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 1'b0, 17'h0,     9'd1, 1'b1, 1'b0};
    tv[6] = '{1'b0, 1'b0, 17'h0,     1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 1'b1, 17'h1ABCD, 9'd1, 1'b1, 1'b0};
    tv[7] = '{1'b0, 1'b0, 17'h0,     1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 1'b0, 17'h0,     9'd0, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) begin
      cyc(tv[i].rst, tv[i].sv, tv[i].sd, tv[i].mr);
      chk($sformatf("tv%0d_s_ready", i), s_ready, tv[i].e_sr);
      chk($sformatf("tv%0d_wr_en", i), ram_wr_en, tv[i].e_we);
      if (tv[i].full) begin
        chk($sformatf("tv%0d_wr_addr", i), ram_wr_addr, tv[i].e_wa);
        chk($sformatf("tv%0d_rd_addr", i), ram_rd_addr, tv[i].e_ra);
        chk($sformatf("tv%0d_m_valid", i), m_valid, tv[i].e_mv);
        if (tv[i].e_mv) chk($sformatf("tv%0d_m_data", i), m_data, tv[i].e_md);
        chk($sformatf("tv%0d_count", i), count, tv[i].e_cnt);
        chk($sformatf("tv%0d_almost_empty", i), almost_empty, tv[i].e_ae);
        chk($sformatf("tv%0d_almost_full", i), almost_full, tv[i].e_af);
      end
    end

    // T3 fill to 258 with no reader, then drain in order.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 1'b1, 17'(acc), 1'b0);
      if (s_ready) acc++;
    end
    chk("fill_accepted", acc, 258);
    cyc(1'b0, 1'b0, 17'h0, 1'b0);
    chk("fill_s_ready", s_ready, 0);
    chk("fill_count", count, 258);
    chk("fill_almost_full", almost_full, 1);
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      cyc(1'b0, 1'b0, 17'h0, 1'b1);
      if (i == 0) chk("drain_s_ready_c0", s_ready, 0);
      if (i == 1) chk("drain_s_ready_back", s_ready, 1);
      if (count == 0) done = 1;
    end
    chk("drain_done", done, 1);
    chk("drain_sb_empty", sb.size(), 0);

    // T4 full-rate streaming.
    do_reset();
    pushed = 0; popped = 0; first_valid = -1; bubbles = 0;
    for (int i = 0; i < 5000 && popped < 1000; i++) begin
      cyc(1'b0, (pushed < 1000), 17'(pushed), 1'b1);
      if (s_valid && s_ready) pushed++;
      if (m_valid) begin
        if (first_valid < 0) first_valid = i;
        popped++;
      end else if (first_valid >= 0) begin
        bubbles++;
      end
    end
    chk("stream_first_valid", first_valid, 3);
    chk("stream_bubbles", bubbles, 0);
    chk("stream_popped", popped, 1000);

    // T5 random valid/ready with pointer wrap.
    do_reset();
    pushed = 0; popped = 0; wraps = 0;
    for (int i = 0; i < 20000 && popped < 2000; i++) begin
      cyc(1'b0, (pushed < 2000) && ($urandom_range(0, 1) == 1),
          17'($urandom_range(0, 131071)), ($urandom_range(0, 1) == 1));
      if (s_valid && s_ready) begin
        pushed++;
        if (ram_wr_addr == 8'd255) wraps++;
      end
      if (m_valid && m_ready) popped++;
    end
    chk("rand_popped", popped, 2000);
    chk("rand_wraps_ge7", (wraps >= 7), 1);

    // T6 reset while a fetch is in flight and the head is occupied.
    do_reset();
    cyc(1'b0, 1'b1, 17'h00011, 1'b0);
    cyc(1'b0, 1'b1, 17'h00022, 1'b0);
    cyc(1'b0, 1'b0, 17'h0, 1'b0);
    cyc(1'b1, 1'b0, 17'h0, 1'b0);
    chk("midrst_pre_m_valid", m_valid, 1);
    chk("midrst_pre_count", count, 2);
    cyc(1'b0, 1'b0, 17'h0, 1'b1);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_count", count, 0);
    chk("midrst_wr_addr", ram_wr_addr, 0);
    cyc(1'b0, 1'b1, 17'h00055, 1'b1);
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      cyc(1'b0, 1'b0, 17'h0, 1'b1);
      if (m_valid) begin
        chk("midrst_first_word", m_data, 17'h00055);
        done = 1;
      end
    end
    chk("midrst_word_seen", done, 1);
    cyc(1'b0, 1'b0, 17'h0, 1'b0);
    chk("midrst_final_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
